hdlverifier_jtag_cmd_decoder: RTL and testbench

HDLVERIFIER_JTAG_CMD_DECODER -- requirements
Module: hdlverifier_jtag_cmd_decoder

---
 rtl/hdlverifier_jtag_cmd_decoder.sv | 118 +++++++++++
 tb/tb_hdlverifier_jtag_cmd_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hdlverifier_jtag_cmd_decoder.sv
// JTAG user-DR command decoder: shifts a {wr, addr, data} frame in on TCK and
// turns each Update-DR into a single register-bank write or a 3-edge read.
module hdlverifier_jtag_cmd_decoder #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              tck,
  input  logic              reset_n,
  input  logic              sel,
  input  logic              capture,
  input  logic              shift,
  input  logic              update,
  input  logic              tdi,
  output logic              tdo,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              write,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD_WAIT  = 2'd2,
    RD_LATCH = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  sr_q, sr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   read_hold_q, read_hold_d;
  logic                write_q, write_d;
  logic                cmd_err_q, cmd_err_d;
  logic                upd;

  assign upd = sel & update;

  // State and datapath registers
  always_ff @(posedge tck) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_hold_q <= '0;
      write_q     <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_hold_q <= read_hold_d;
      write_q     <= write_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Shift register, command FSM and register-bank handshake
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_hold_d = read_hold_q;
    write_d     = 1'b0;
    cmd_err_d   = cmd_err_q;

    // Capture wins over shift; both see the pre-latch read_hold
    if (sel && capture) begin
      sr_d = {1'b0, addr_q, read_hold_q};
    end else if (sel && shift) begin
      sr_d = {tdi, sr_q[FRAME_W-1:1]};
    end

    unique case (state_q)
      IDLE: begin
        if (upd) begin
          addr_d = sr_q[DATA_W +: ADDR_W];
          if (sr_q[FRAME_W-1]) begin
            wdata_d = sr_q[DATA_W-1:0];
            write_d = 1'b1;
            state_d = WR;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      WR: begin
        state_d = IDLE;
        if (upd) cmd_err_d = 1'b1;
      end
      RD_WAIT: begin
        state_d = RD_LATCH;
        if (upd) cmd_err_d = 1'b1;
      end
      RD_LATCH: begin
        read_hold_d = rdata;
        state_d     = IDLE;
        if (upd) cmd_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tdo     = sr_q[0];
  assign addr    = addr_q;
  assign wdata   = wdata_q;
  assign write   = write_q;
  assign busy    = (state_q != IDLE);
  assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_hdlverifier_jtag_cmd_decoder.sv
// Directed self-checking bench for the JTAG command decoder with a small
// registered register-bank model driving rdata.
module tb_hdlverifier_jtag_cmd_decoder;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;

  logic              tck;
  logic              reset_n;
  logic              sel;
  logic              capture;
  logic              shift;
  logic              update;
  logic              tdi;
  logic              tdo;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              write;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              cmd_err;

  int checks = 0;
  int errors = 0;

  hdlverifier_jtag_cmd_decoder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .tck     (tck),
    .reset_n (reset_n),
    .sel     (sel),
    .capture (capture),
    .shift   (shift),
    .update  (update),
    .tdi     (tdi),
    .tdo     (tdo),
    .addr    (addr),
    .wdata   (wdata),
    .write   (write),
    .rdata   (rdata),
    .busy    (busy),
    .cmd_err (cmd_err)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  // Register bank: address 3 returns a fixed word, one-cycle read latency
  always @(posedge tck) begin
    rdata <= (addr == 5'd3) ? 32'h1234_5678 : (32'hFFFF_0000 | 32'(addr));
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge tck);
  endtask

  task automatic shift_frame(input logic [FRAME_W-1:0] f);
    for (int i = 0; i < int'(FRAME_W); i++) begin
      sel = 1'b1; shift = 1'b1; tdi = f[i];
      tick();
    end
    shift = 1'b0; tdi = 1'b0;
  endtask

  task automatic read_sr(output logic [FRAME_W-1:0] v);
    v = '0;
    for (int i = 0; i < int'(FRAME_W); i++) begin
      v[i] = tdo;
      sel = 1'b1; shift = 1'b1; tdi = 1'b0;
      tick();
    end
    shift = 1'b0;
  endtask

  task automatic do_capture();
    sel = 1'b1; capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  logic [FRAME_W-1:0] got;
  logic [FRAME_W-1:0] frame;

  initial begin
    reset_n = 1'b0; sel = 1'b1; capture = 1'b0; shift = 1'b0;
    update = 1'b1; tdi = 1'b0;
    tick(); tick();
    // Reset overrides a same-cycle update
    check("rst_addr",  64'(addr),    64'd0);
    check("rst_wdata", 64'(wdata),   64'd0);
    check("rst_write", 64'(write),   64'd0);
    check("rst_busy",  64'(busy),    64'd0);
    check("rst_err",   64'(cmd_err), 64'd0);
    check("rst_tdo",   64'(tdo),     64'd0);
    update = 1'b0; reset_n = 1'b1;
    tick();

    // Write command
    shift_frame({1'b1, 5'd2, 32'hDEAD_BEEF});
    update = 1'b1;
    tick();
    update = 1'b0;
    check("wr_addr",  64'(addr),  64'd2);
    check("wr_wdata", 64'(wdata), 64'hDEAD_BEEF);
    check("wr_write", 64'(write), 64'd1);
    check("wr_busy",  64'(busy),  64'd1);
    tick();
    check("wr_write_off", 64'(write), 64'd0);
    check("wr_busy_off",  64'(busy),  64'd0);
    check("wr_hold",      64'(wdata), 64'hDEAD_BEEF);

    // Read round trip; capture coinciding with RD_LATCH sees the old word
    shift_frame({1'b0, 5'd3, 32'hFFFF_FFFF});
    update = 1'b1;
    tick();
    update = 1'b0;
    check("rd_addr",  64'(addr),  64'd3);
    check("rd_wdata", 64'(wdata), 64'hDEAD_BEEF);
    check("rd_write", 64'(write), 64'd0);
    check("rd_busy0", 64'(busy),  64'd1);
    tick();
    check("rd_busy1", 64'(busy),  64'd1);
    do_capture();
    check("rd_busy2", 64'(busy),  64'd0);
    read_sr(got);
    check("rd_cap_prelatch", 64'(got), 64'({1'b0, 5'd3, 32'd0}));
    do_capture();
    read_sr(got);
    check("rd_data", 64'(got[31:0]),  64'h1234_5678);
    check("rd_adr",  64'(got[36:32]), 64'd3);
    check("rd_flag", 64'(got[37]),    64'd0);

    // Capture and shift together: capture load wins
    sel = 1'b1; capture = 1'b1; shift = 1'b1; tdi = 1'b1;
    tick();
    capture = 1'b0; shift = 1'b0; tdi = 1'b0;
    read_sr(got);
    check("cap_shift", 64'(got), 64'({1'b0, 5'd3, 32'h1234_5678}));

    // Strobes ignored while sel is low
    frame = {1'b1, 5'd9, 32'hA5A5_A5A5};
    shift_frame(frame);
    sel = 1'b0; shift = 1'b1; tdi = 1'b1;
    for (int i = 0; i < int'(FRAME_W); i++) tick();
    shift = 1'b0; update = 1'b1; capture = 1'b1;
    tick();
    update = 1'b0; capture = 1'b0;
    tick();
    check("nosel_addr",  64'(addr),    64'd3);
    check("nosel_write", 64'(write),   64'd0);
    check("nosel_busy",  64'(busy),    64'd0);
    check("nosel_err",   64'(cmd_err), 64'd0);
    read_sr(got);
    check("nosel_sr",    64'(got),     64'(frame));

    // Reset in RD_WAIT aborts the read
    shift_frame({1'b0, 5'd3, 32'd0});
    update = 1'b1;
    tick();
    update = 1'b0;
    check("mid_busy_pre", 64'(busy), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_busy_rst", 64'(busy), 64'd0);
    tick(); tick();
    check("mid_busy_after", 64'(busy), 64'd0);
    do_capture();
    read_sr(got);
    check("mid_cap_zero", 64'(got), 64'd0);

    // Update while busy is dropped and flags a sticky error
    shift_frame({1'b0, 5'd3, 32'd0});
    update = 1'b1;
    tick();
    check("col_addr0", 64'(addr), 64'd3);
    tick();
    update = 1'b0;
    check("col_err",   64'(cmd_err), 64'd1);
    check("col_addr1", 64'(addr),    64'd3);
    check("col_busy1", 64'(busy),    64'd1);
    tick();
    check("col_busy2", 64'(busy),    64'd0);
    shift_frame({1'b1, 5'd7, 32'hCAFE_F00D});
    update = 1'b1;
    tick();
    update = 1'b0;
    check("col_wr_ok",  64'(write),   64'd1);
    check("col_sticky", 64'(cmd_err), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("col_err_clr", 64'(cmd_err), 64'd0);
    check("col_wr_clr",  64'(write),   64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
